inst_mem_loader: RTL and testbench

- Write-side companion to the byte-addressed instruction memory. The core's fetch path reads that memory.
- Accepts a framed byte stream (sync, length, payload, checksum) over a valid/ready handshake.
- Writes each payload byte to consecutive memory addresses, in stream order, through a one-byte write port.
- Instruction words are stored MSB byte at the lowest address. The host therefore sends each 32-bit instruction MSB byte first.
- Holds the core (cpu_hold) while a load is in flight and after a failed load.

---
 rtl/inst_mem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader that writes the instruction memory and holds the core until a good image lands.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module inst_mem_loader #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MEM_BYTES      = 256,
  parameter int unsigned BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [15:0]       bytes_loaded
);

  localparam int unsigned END_W = 33;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
`ifdef LOADER_TIMEOUT_EN
  localparam logic [1:0]  ERR_TMO  = 2'd3;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

  if (MEM_BYTES == 0 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("inst_mem_loader: MEM_BYTES must be nonzero and TIMEOUT_CYCLES in 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        acc_q, acc_d;
  logic [15:0]       bytes_loaded_q, bytes_loaded_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
`ifdef LOADER_TIMEOUT_EN
  logic [15:0]       tmo_q, tmo_d;
`endif

  logic              xfer_c;
  logic [15:0]       len_new_c;
  logic [END_W-1:0]  frame_end_c;
  logic [7:0]        csum_c;

  assign xfer_c      = in_valid && in_ready_q;
  assign len_new_c   = {len_q[15:8], in_data};
  assign frame_end_c = END_W'(BASE_ADDR) + END_W'(len_new_c);
  assign csum_c      = acc_q + in_data;

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    acc_d          = acc_q;
    bytes_loaded_d = bytes_loaded_q;
    err_code_d     = err_code_q;
    cpu_hold_d     = cpu_hold_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    load_done_d    = 1'b0;
    load_err_d     = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    tmo_d          = 16'd0;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer_c && in_data == SYNC_BYTE) begin
          cpu_hold_d     = 1'b1;
          err_code_d     = ERR_NONE;
          bytes_loaded_d = 16'd0;
          acc_d          = 8'd0;
          state_d        = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d[7:0] = in_data;
          if (frame_end_c > END_W'(MEM_BYTES)) begin
            err_code_d = ERR_LEN;
            load_err_d = 1'b1;
            state_d    = S_RESP;
          end else if (len_new_c == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          mem_we_d       = 1'b1;
          mem_addr_d     = ADDR_W'(BASE_ADDR) + ADDR_W'(bytes_loaded_q);
          mem_wdata_d    = in_data;
          bytes_loaded_d = bytes_loaded_q + 16'd1;
          acc_d          = csum_c;
          if (bytes_loaded_q + 16'd1 == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer_c) begin
          if (csum_c == 8'd0) begin
            err_code_d  = ERR_NONE;
            load_done_d = 1'b1;
          end else begin
            err_code_d = ERR_CSUM;
            load_err_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A failed frame leaves the core held; only success releases it
        if (err_code_q == ERR_NONE) begin
          cpu_hold_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    if (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA || state_q == S_CSUM) begin
      if (!xfer_c) begin
        if (tmo_q == TMO_LAST) begin
          err_code_d = ERR_TMO;
          load_err_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
    end
`endif

    in_ready_d = (state_d != S_RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= 16'd0;
      acc_q          <= 8'd0;
      bytes_loaded_q <= 16'd0;
      err_code_q     <= ERR_NONE;
      cpu_hold_q     <= 1'b0;
      in_ready_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 8'd0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q          <= 16'd0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      acc_q          <= acc_d;
      bytes_loaded_q <= bytes_loaded_d;
      err_code_q     <= err_code_d;
      cpu_hold_q     <= cpu_hold_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign err_code     = err_code_q;
  assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: good/bad frames, overflow, garbage, zero length, stall/timeout, reset mid-frame.
module tb_inst_mem_loader;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;
  logic [15:0] bytes_loaded;

  inst_mem_loader #(
    .ADDR_W(32),
    .MEM_BYTES(256),
    .BASE_ADDR(0),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .err_code(err_code),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int lerr_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  seq[$];
  logic [7:0]  exp_wr[$];

  // Log writes and response pulses mid-cycle
  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
    if (load_err) lerr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 4) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!in_ready) check_eq("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_addr.size(); i++) begin
      check_eq({tag, "_addr"}, wr_addr[i], 32'(i));
      check_eq({tag, "_data"}, 32'(wr_data[i]), 32'(exp_wr[i]));
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_done_err", 32'({load_done, load_err, err_code}), 32'd0);
    check_eq("rst_bytes", 32'(bytes_loaded), 32'd0);
    repeat (2) clk1();
    reset = 1'b0;
    check_eq("rel_ready0", 32'(in_ready), 32'd0);
    clk1();
    check_eq("rel_ready1", 32'(in_ready), 32'd1);

    // Good frame
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h40, 8'h01, 8'h13, 8'hAC};
    send_seq();
    check_eq("good_done", 32'(load_done), 32'd1);
    check_eq("good_err", 32'(load_err), 32'd0);
    check_eq("good_code", 32'(err_code), 32'd0);
    check_eq("good_bytes", 32'(bytes_loaded), 32'd4);
    check_eq("good_hold_resp", 32'(cpu_hold), 32'd1);
    check_eq("good_ready_resp", 32'(in_ready), 32'd0);
    clk1();
    check_eq("good_hold_after", 32'(cpu_hold), 32'd0);
    check_eq("good_done_pulse", 32'(load_done), 32'd0);
    check_eq("good_ready_after", 32'(in_ready), 32'd1);
    exp_wr = '{8'h00, 8'h40, 8'h01, 8'h13};
    check_writes("good");

    // Bad checksum, then resend
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h40, 8'h01, 8'h13, 8'hAD};
    send_seq();
    check_eq("csum_err", 32'(load_err), 32'd1);
    check_eq("csum_done", 32'(load_done), 32'd0);
    check_eq("csum_code", 32'(err_code), 32'd2);
    clk1();
    check_eq("csum_hold", 32'(cpu_hold), 32'd1);
    check_writes("csum");
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h40, 8'h01, 8'h13, 8'hAC};
    send_seq();
    check_eq("resend_done", 32'(load_done), 32'd1);
    check_eq("resend_code", 32'(err_code), 32'd0);
    clk1();
    check_eq("resend_hold", 32'(cpu_hold), 32'd0);
    check_writes("resend");

    // Length overflow (257 > 256)
    clear_log();
    seq = '{8'hA5, 8'h01, 8'h01};
    send_seq();
    check_eq("ovf_err", 32'(load_err), 32'd1);
    check_eq("ovf_code", 32'(err_code), 32'd1);
    check_eq("ovf_ready", 32'(in_ready), 32'd0);
    send_byte(8'h00);
    clk1();
    check_eq("ovf_code_held", 32'(err_code), 32'd1);
    check_eq("ovf_hold", 32'(cpu_hold), 32'd1);
    check_eq("ovf_bytes", 32'(bytes_loaded), 32'd0);
    exp_wr.delete();
    check_writes("ovf");

    // Leading garbage then zero-length frame
    clear_log();
    seq = '{8'h00, 8'hFF, 8'h12};
    send_seq();
    check_eq("garb_code", 32'(err_code), 32'd1);
    check_eq("garb_hold", 32'(cpu_hold), 32'd1);
    seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    check_eq("zero_done", 32'(load_done), 32'd1);
    check_eq("zero_code", 32'(err_code), 32'd0);
    check_eq("zero_bytes", 32'(bytes_loaded), 32'd0);
    clk1();
    check_eq("zero_hold", 32'(cpu_hold), 32'd0);
    check_writes("zero");

    // Sync value inside the payload is plain data
    clear_log();
    seq = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5B};
    send_seq();
    check_eq("syncdata_done", 32'(load_done), 32'd1);
    check_eq("syncdata_bytes", 32'(bytes_loaded), 32'd1);
    clk1();
    exp_wr = '{8'hA5};
    check_writes("syncdata");

    // Stall mid-payload
    begin
      int e0;
      int d0;
      clear_log();
      e0 = lerr_cnt;
      d0 = done_cnt;
      seq = '{8'hA5, 8'h00, 8'h04, 8'h40};
      send_seq();
      repeat (10) clk1();
      exp_wr = '{8'h40};
      check_writes("stall");
      check_eq("stall_bytes", 32'(bytes_loaded), 32'd1);
      check_eq("stall_hold", 32'(cpu_hold), 32'd1);
      check_eq("stall_ready", 32'(in_ready), 32'd1);
`ifdef LOADER_TIMEOUT_EN
      check_eq("tmo_err_pulses", 32'(lerr_cnt - e0), 32'd1);
      check_eq("tmo_code", 32'(err_code), 32'd3);
`else
      check_eq("stall_err_pulses", 32'(lerr_cnt - e0), 32'd0);
      check_eq("stall_code", 32'(err_code), 32'd0);
      seq = '{8'h01, 8'h13, 8'hAC, 8'h00};
      send_seq();
      check_eq("stall_done", 32'(load_done), 32'd1);
      clk1();
      check_eq("stall_done_pulses", 32'(done_cnt - d0), 32'd1);
      check_eq("stall_hold_after", 32'(cpu_hold), 32'd0);
      exp_wr = '{8'h40, 8'h01, 8'h13, 8'hAC};
      check_writes("stall_full");
`endif
    end

    // Reset mid-frame
    seq = '{8'hA5, 8'h00, 8'h02, 8'h11};
    send_seq();
    check_eq("midrst_hold_pre", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_hold", 32'(cpu_hold), 32'd0);
    check_eq("midrst_bytes", 32'(bytes_loaded), 32'd0);
    check_eq("midrst_we", 32'(mem_we), 32'd0);
    clk1();
    reset = 1'b0;
    clk1();
    check_eq("midrst_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
